// File: rtl/seq_preamble_tx_pkg.sv
// Shared definitions for the preamble transmitter and the matching 101 detector bench.
package seq_preamble_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam int              PRE_LEN  = 3;
    localparam logic [PRE_LEN-1:0] PREAMBLE = 3'b101;

    // Preamble bit for a given send index; index 0 is sent first (MSB of PREAMBLE).
    function automatic logic preamble_bit(input logic [1:0] idx);
        case (idx)
            2'd0:    return PREAMBLE[2];
            2'd1:    return PREAMBLE[1];
            default: return PREAMBLE[0];
        endcase
    endfunction

endpackage

// File: rtl/seq_piso_shreg.sv
// Parallel-load, serial-out shift register, MSB first; load wins over shift.
module seq_piso_shreg #(
    parameter int NBITS = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             shift,
    input  logic [NBITS-1:0] din,
    output logic             msb
);

    logic [NBITS-1:0] sr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            sr <= '0;
        else if (load)
            sr <= din;
        else if (shift)
            sr <= {sr[NBITS-2:0], 1'b0};
    end

    assign msb = sr[NBITS-1];

endmodule

// File: rtl/seq_preamble_tx.sv
// Serial frame transmitter: 101 preamble followed by an NBITS payload, MSB first.
module seq_preamble_tx
    import seq_preamble_tx_pkg::*;
#(
    parameter int NBITS = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [NBITS-1:0] in_,
    input  logic             in_val,
    output logic             in_rdy,
    output logic             out,
    output logic             out_val,
    output logic             frame_end
);

    localparam int             CW       = $clog2(NBITS);
    localparam logic [CW-1:0]  LAST_BIT = CW'(NBITS - 1);

    state_t        state, state_nx;
    logic [1:0]    pre_idx, pre_idx_nx;
    logic [CW-1:0] bit_idx, bit_idx_nx;
    logic          xfer;
    logic          last_bit;
    logic          sr_msb;

    // Ready in the final payload cycle lets the next frame follow with no gap.
    assign last_bit = (state == DATA) && (bit_idx == '0);
    assign in_rdy   = (state == IDLE) || last_bit;
    assign xfer     = in_val && in_rdy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            pre_idx <= '0;
            bit_idx <= '0;
        end else begin
            state   <= state_nx;
            pre_idx <= pre_idx_nx;
            bit_idx <= bit_idx_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        pre_idx_nx = pre_idx;
        bit_idx_nx = bit_idx;
        case (state)
            IDLE: begin
                if (xfer) begin
                    state_nx   = PRE;
                    pre_idx_nx = '0;
                end
            end
            PRE: begin
                if (pre_idx == 2'(PRE_LEN - 1)) begin
                    state_nx   = DATA;
                    pre_idx_nx = '0;
                    bit_idx_nx = LAST_BIT;
                end else begin
                    pre_idx_nx = pre_idx + 2'd1;
                end
            end
            DATA: begin
                if (bit_idx == '0) begin
                    state_nx   = xfer ? PRE : IDLE;
                    pre_idx_nx = '0;
                end else begin
                    bit_idx_nx = bit_idx - 1'b1;
                end
            end
            default: begin
                state_nx   = IDLE;
                pre_idx_nx = '0;
                bit_idx_nx = '0;
            end
        endcase
    end

    // Outputs depend only on registered state, never on in_val or in_.
    always_comb begin
        out       = 1'b0;
        out_val   = 1'b0;
        frame_end = 1'b0;
        case (state)
            PRE: begin
                out     = preamble_bit(pre_idx);
                out_val = 1'b1;
            end
            DATA: begin
                out       = sr_msb;
                out_val   = 1'b1;
                frame_end = last_bit;
            end
            default: ;
        endcase
    end

    seq_piso_shreg #(.NBITS(NBITS)) u_shreg (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (xfer),
        .shift   (state == DATA),
        .din     (in_),
        .msb     (sr_msb)
    );

endmodule

// File: tb/tb_seq_preamble_tx.sv
// Scoreboard bench for seq_preamble_tx: frame-level model, bit monitor, 101 loopback detector.
module tb_seq_preamble_tx;

    localparam int NBITS = 8;
    localparam int FLEN  = NBITS + 3;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [NBITS-1:0] in_ = '0;
    logic             in_val = 1'b0;
    logic             in_rdy, out, out_val, frame_end;

    seq_preamble_tx #(.NBITS(NBITS)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_       (in_),
        .in_val    (in_val),
        .in_rdy    (in_rdy),
        .out       (out),
        .out_val   (out_val),
        .frame_end (frame_end)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic b;
        logic fe;
        logic pe;
    } exp_t;

    exp_t exp_q[$];
    int   rem = 0;           // cycles of the frame in flight still to be output
    bit   xfer_seen = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Frame-level reference: a word is taken when idle or in the final bit of a frame.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exp_q.delete();
            rem = 0;
            xfer_seen = 0;
        end else begin
            xfer_seen = in_val && (rem <= 1);
            if (xfer_seen) begin
                logic [2:0] pre_pat;
                pre_pat = 3'b101;
                for (int i = 0; i < 3; i++)
                    exp_q.push_back('{b: pre_pat[2-i], fe: 1'b0, pe: (i == 2)});
                for (int i = 0; i < NBITS; i++)
                    exp_q.push_back('{b: in_[NBITS-1-i], fe: (i == NBITS-1), pe: 1'b0});
                rem = FLEN;
            end else if (rem > 0) begin
                rem = rem - 1;
            end
        end
    end

    // Loopback Moore 101 detector on the raw serial line.
    logic [2:0] hist;
    logic       det;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) hist <= '0;
        else          hist <= {hist[1:0], out};
    end
    assign det = (hist == 3'b101);

    bit prev_pe = 0;
    always @(negedge clk) begin
        exp_t e;
        chk("in_rdy", 32'(in_rdy), 32'(rem <= 1));
        if (prev_pe) chk("detector", 32'(det), 32'd1);
        prev_pe = 0;
        if (out_val) begin
            chk("q_nonempty", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("out_bit", 32'(out), 32'(e.b));
                chk("frame_end", 32'(frame_end), 32'(e.fe));
                prev_pe = e.pe;
            end
        end else begin
            chk("idle_out", 32'(out), 32'd0);
            chk("idle_frame_end", 32'(frame_end), 32'd0);
            chk("gap", 32'(exp_q.size()), 32'd0);
        end
    end

    task automatic send(input logic [NBITS-1:0] w, input bit jitter);
        int n;
        n = 0;
        in_ = w;
        in_val = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (xfer_seen) break;
            n++;
            if (n > 100) begin
                chk("send_timeout", 32'd1, 32'd0);
                break;
            end
            if (jitter) in_ = NBITS'($urandom);
        end
        in_val = 1'b0;
        in_ = NBITS'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((rem != 0 || exp_q.size() != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (n >= 200) chk("idle_timeout", 32'd1, 32'd0);
        #1;
    endtask

    initial begin
        // Reset held with a valid word offered: nothing may be taken.
        reset_n = 1'b0;
        in_val  = 1'b1;
        in_     = 8'h55;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_val", 32'(out_val), 32'd0);
        chk("rst_in_rdy", 32'(in_rdy), 32'd1);
        in_val  = 1'b0;
        reset_n = 1'b1;

        send(8'hA5, 1'b0);
        wait_idle();

        // Back-to-back frames with valid held across the boundary.
        send(8'hFF, 1'b0);
        send(8'h00, 1'b0);
        wait_idle();

        // Backpressure: raise valid on cycle 2 of a frame while in_ wanders.
        send(8'hC3, 1'b0);
        @(posedge clk);
        #1;
        send(NBITS'($urandom), 1'b1);
        wait_idle();

        // Abort during payload bit 3, then a clean frame.
        send(8'h5A, 1'b0);
        repeat (7) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort_out_val", 32'(out_val), 32'd0);
        chk("abort_out", 32'(out), 32'd0);
        chk("abort_in_rdy", 32'(in_rdy), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        send(8'h3C, 1'b0);
        wait_idle();

        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                in_val = 1'b0;
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1;
            end
            send(NBITS'($urandom), 1'($urandom_range(0, 1)));
        end
        wait_idle();
        repeat (3) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
